kmkz_regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the Kamikaze-uRV pipeline. It generalises the 2R1W regfile to a configurable data width, depth and read-port count. It keeps W-stage and X-stage result forwarding, and adds two things the 2R1W block lacks: a post-reset clear sequencer, and correct forwarding of writes that land while decode is stalled. It sits between decode (read addresses) and execute (operand values), with its write port driven by writeback.

---
 rtl/kmkz_rf_pkg.sv | 18 +
 rtl/kmkz_regmem_1r1w.sv | 35 +++
 rtl/kmkz_regfile_mp.sv | 138 +++++++++++++
 tb/tb_kmkz_regfile_mp.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/kmkz_rf_pkg.sv
// Shared types and helpers for the Kamikaze-uRV multi-port register file.
package kmkz_rf_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } rf_state_t;

    localparam int unsigned RF_DATA_W_DEF = 32;
    localparam int unsigned RF_ADDR_W_DEF = 5;
    localparam int unsigned RF_NUM_RD_DEF = 2;

    // Bit offset of port p inside a flattened per-port bus of width w
    function automatic int unsigned port_off(input int unsigned p, input int unsigned w);
        return p * w;
    endfunction

endpackage

// File: rtl/kmkz_regmem_1r1w.sv
// One register-file bank: synchronous-read RAM, one write port, resettable read register.
module kmkz_regmem_1r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Same-cycle write to raddr_i returns the old contents
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/kmkz_regfile_mp.sv
// Multi-read-port register file with W/X forwarding, stall-time late-write capture
// and a post-reset clear sequencer.
module kmkz_regfile_mp
    import kmkz_rf_pkg::*;
#(
    parameter int unsigned DATA_W         = RF_DATA_W_DEF,
    parameter int unsigned ADDR_W         = RF_ADDR_W_DEF,
    parameter int unsigned NUM_RD         = RF_NUM_RD_DEF,
    parameter bit          ZERO_REG       = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       d_stall_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rf_rs_i,
    input  logic [NUM_RD*ADDR_W-1:0]   d_rs_i,
    output logic [NUM_RD*DATA_W-1:0]   x_rs_value_o,
    input  logic [ADDR_W-1:0]          w_rd_i,
    input  logic [DATA_W-1:0]          w_rd_value_i,
    input  logic                       w_rd_store_i,
    input  logic                       w_bypass_rd_write_i,
    input  logic [DATA_W-1:0]          w_bypass_rd_value_i,
    output logic                       init_busy_o
);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              zero_wr;
    logic              we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] x_val [NUM_RD];

    assign zero_wr = ZERO_REG && (w_rd_i == '0);
    assign we      = w_rd_store_i && !init_busy_o && !zero_wr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && cnt_q == '1) begin
            state_d = ST_RUN;
        end
    end

    // Clear sequencer borrows the shared bank write port while busy
    always_comb begin
        init_busy_o = (state_q == ST_CLEAR);
        mem_we      = we;
        mem_addr    = w_rd_i;
        mem_data    = w_rd_value_i;
        if (state_q == ST_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_data = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            cnt_q <= cnt_q + ADDR_W'(1);
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        localparam int unsigned AO = port_off(p, ADDR_W);

        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] drs;
        logic [DATA_W-1:0] ram_q;
        logic [DATA_W-1:0] bval_q;
        logic              wflag_q;
        logic              xhit;

        assign rs   = rf_rs_i[AO +: ADDR_W];
        assign drs  = d_rs_i[AO +: ADDR_W];
        assign xhit = w_bypass_rd_write_i && (w_rd_i == drs) && !zero_wr;

        kmkz_regmem_1r1w #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .re_i    (!d_stall_i),
            .raddr_i (rs),
            .rdata_o (ram_q),
            .we_i    (mem_we),
            .waddr_i (mem_addr),
            .wdata_i (mem_data)
        );

        // Under stall the RAM register is frozen, so a write to the held index is captured here
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                wflag_q <= 1'b0;
                bval_q  <= '0;
            end else if (!d_stall_i) begin
                wflag_q <= we && (rs == w_rd_i);
                if (we && (rs == w_rd_i)) begin
                    bval_q <= w_rd_value_i;
                end
            end else if (we && (drs == w_rd_i)) begin
                wflag_q <= 1'b1;
                bval_q  <= w_rd_value_i;
            end
        end

        always_comb begin
            if (ZERO_REG && drs == '0) begin
                x_val[p] = '0;
            end else if (xhit) begin
                x_val[p] = w_bypass_rd_value_i;
            end else if (wflag_q) begin
                x_val[p] = bval_q;
            end else begin
                x_val[p] = ram_q;
            end
        end
    end

    always_comb begin
        x_rs_value_o = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            x_rs_value_o[port_off(i, DATA_W) +: DATA_W] = x_val[i];
        end
    end

endmodule

// File: tb/tb_kmkz_regfile_mp.sv
// Directed-vector bench for kmkz_regfile_mp (defaults: 32-bit, 32 entries, 2 read ports).
module tb_kmkz_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_stall;
    logic [NR*AW-1:0] rf_rs;
    logic [NR*AW-1:0] d_rs;
    logic [NR*DW-1:0] x_val;
    logic [AW-1:0]    w_rd;
    logic [DW-1:0]    w_val;
    logic             w_store;
    logic             byp_wr;
    logic [DW-1:0]    byp_val;
    logic             init_busy;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    int          n;

    always #5 clk = ~clk;

    kmkz_regfile_mp #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .NUM_RD         (NR),
        .ZERO_REG       (1'b1),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .d_stall_i           (d_stall),
        .rf_rs_i             (rf_rs),
        .d_rs_i              (d_rs),
        .x_rs_value_o        (x_val),
        .w_rd_i              (w_rd),
        .w_rd_value_i        (w_val),
        .w_rd_store_i        (w_store),
        .w_bypass_rd_write_i (byp_wr),
        .w_bypass_rd_value_i (byp_val),
        .init_busy_o         (init_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: decode register copies rf_rs into d_rs unless stalled
    task automatic tick();
        @(posedge clk);
        #1;
        if (!d_stall) d_rs = rf_rs;
        #1;
    endtask

    task automatic busy_len(output int len);
        len = 0;
        while (init_busy && len < 100) begin
            tick();
            len++;
        end
    endtask

    initial begin
        rst = 1'b0; d_stall = 1'b0; rf_rs = '0; d_rs = '0;
        w_rd = '0; w_val = '0; w_store = 1'b0; byp_wr = 1'b0; byp_val = '0;
        #12;
        chk("rst_busy", 64'(init_busy), 64'd1);
        chk("rst_xval", x_val, 64'd0);

        // Reset release with a dropped write to x5 while clearing
        w_rd = 5'd5; w_val = 32'hDEADBEEF; w_store = 1'b1;
        @(negedge clk); rst = 1'b1;
        busy_len(n);
        chk("clear_len", 64'(n), 64'd32);
        w_store = 1'b0; w_rd = '0;
        for (int i = 1; i < 32; i++) begin
            rf_rs = {5'(32 - i), 5'(i)};
            tick();
            chk("clear_p0", 64'(x_val[31:0]), 64'd0);
            chk("clear_p1", 64'(x_val[63:32]), 64'd0);
        end
        rf_rs = {5'd5, 5'd5};
        tick();
        chk("x5_dropped", x_val, 64'd0);

        // W-forward of a same-cycle write
        rf_rs = {5'd7, 5'd7}; w_rd = 5'd7; w_val = 32'h12345678; w_store = 1'b1;
        tick();
        w_store = 1'b0; w_rd = '0; #1;
        chk("wfwd_p0", 64'(x_val[31:0]), 64'h12345678);
        chk("wfwd_p1", 64'(x_val[63:32]), 64'h12345678);
        tick();
        chk("x7_ram", 64'(x_val[31:0]), 64'h12345678);

        // X-forward beats W-forward
        rf_rs = {5'd9, 5'd7}; w_rd = 5'd9; w_val = 32'h11112222; w_store = 1'b1;
        tick();
        w_store = 1'b0; byp_wr = 1'b1; byp_val = 32'hA5A5A5A5; #1;
        chk("xfwd_p1", 64'(x_val[63:32]), 64'hA5A5A5A5);
        chk("xfwd_p0", 64'(x_val[31:0]), 64'h12345678);
        byp_wr = 1'b0; #1;
        chk("wfwd_p1", 64'(x_val[63:32]), 64'h11112222);
        w_rd = '0;

        // Late write under stall
        rf_rs = {5'd3, 5'd3};
        tick();
        chk("x3_pre", x_val, 64'd0);
        d_stall = 1'b1; rf_rs = {5'd7, 5'd7};
        tick();
        chk("stall_hold", x_val, 64'd0);
        w_rd = 5'd3; w_val = 32'h55; w_store = 1'b1;
        tick();
        w_store = 1'b0; w_rd = '0; #1;
        chk("late_p0", 64'(x_val[31:0]), 64'h55);
        chk("late_p1", 64'(x_val[63:32]), 64'h55);
        tick();
        chk("late_hold", x_val, {32'h55, 32'h55});
        d_stall = 1'b0; rf_rs = {5'd3, 5'd3};
        tick();
        chk("unstall_x3", x_val, {32'h55, 32'h55});

        // Zero register: write and X-bypass both ignored
        rf_rs = {5'd0, 5'd0}; w_rd = 5'd0; w_val = 32'hFFFFFFFF; w_store = 1'b1;
        tick();
        w_store = 1'b0; byp_wr = 1'b1; byp_val = 32'hCAFEBABE; #1;
        chk("x0_zero", x_val, 64'd0);
        byp_wr = 1'b0;

        // Reset mid-clear restarts a full clear
        rst = 1'b0; #1;
        chk("rst2_busy", 64'(init_busy), 64'd1);
        chk("rst2_xval", x_val, 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (10) tick();
        chk("busy_mid", 64'(init_busy), 64'd1);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        busy_len(n);
        chk("reclear_len", 64'(n), 64'd32);
        rf_rs = {5'd3, 5'd7};
        tick();
        chk("recleared", x_val, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
